// File: rtl/multi_chan_synchronizer.sv
// Multi-channel synchroniser: per-channel flop chain, debounce filter,
// registered edge pulses and software-clearable sticky event flags.
// Channels are independent; do not pass multi-bit buses through this block.
module multi_chan_synchronizer #(
   parameter int                      NUM_CHANNELS = 8,
   parameter int                      SYNC_STAGES  = 2,
   parameter int                      DEBOUNCE_LEN = 1,
   parameter logic [NUM_CHANNELS-1:0] RESET_VAL    = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CHANNELS-1:0] async_in,
   input  logic [NUM_CHANNELS-1:0] evt_clr,
   output logic [NUM_CHANNELS-1:0] level_out,
   output logic [NUM_CHANNELS-1:0] rise_pulse,
   output logic [NUM_CHANNELS-1:0] fall_pulse,
   output logic [NUM_CHANNELS-1:0] evt_sticky
);

   // Counter only has to reach DEBOUNCE_LEN-1, so it never wraps.
   localparam int               CNT_W   = (DEBOUNCE_LEN <= 2) ? 1 : $clog2(DEBOUNCE_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LEN - 1);

   (* ASYNC_REG = "TRUE" *) logic [NUM_CHANNELS-1:0] chain_q [SYNC_STAGES];
   logic [NUM_CHANNELS-1:0] sync_s;
   logic [NUM_CHANNELS-1:0] flip;

   // Plain flop chain: nothing may sit between stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) chain_q[k] <= RESET_VAL;
      end else begin
         chain_q[0] <= async_in;
         for (int k = 1; k < SYNC_STAGES; k++) chain_q[k] <= chain_q[k-1];
      end
   end

   assign sync_s = chain_q[SYNC_STAGES-1];

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      logic [CNT_W-1:0] cnt_q;

      // A channel flips once the synchronised value has disagreed with the
      // current level for DEBOUNCE_LEN consecutive edges.
      assign flip[i] = (sync_s[i] != level_out[i]) && (cnt_q == CNT_MAX);

      // Debounce counter: restarts whenever the input agrees or a flip lands.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= '0;
         end else if ((sync_s[i] == level_out[i]) || flip[i]) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Level, edge pulses and sticky flags all update on the edge that flips.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_out  <= RESET_VAL;
         rise_pulse <= '0;
         fall_pulse <= '0;
         evt_sticky <= '0;
      end else begin
         level_out  <= level_out ^ flip;
         rise_pulse <= flip & sync_s;
         fall_pulse <= flip & ~sync_s;
         evt_sticky <= flip | (evt_sticky & ~evt_clr);
      end
   end

endmodule

// File: tb/tb_multi_chan_synchronizer.sv
// Bench for multi_chan_synchronizer: a vector table on a short, unfiltered
// instance plus directed and randomised traffic on a 16-channel debounced
// instance checked against a window-based reference model.
module tb_multi_chan_synchronizer;

   localparam int          NA  = 16;
   localparam int          SSA = 3;
   localparam int          DLA = 4;
   localparam logic [15:0] RVA = 16'h5AA5;

   logic        clk;
   logic        rst_a, rst_b;
   logic [15:0] in_a, clr_a, lvl_a, rise_a, fall_a, stk_a;
   logic [7:0]  in_b, clr_b, lvl_b, rise_b, fall_b, stk_b;

   int total = 0;
   int bad   = 0;

   multi_chan_synchronizer #(
      .NUM_CHANNELS(NA), .SYNC_STAGES(SSA), .DEBOUNCE_LEN(DLA), .RESET_VAL(RVA)
   ) dut_a (
      .clk(clk), .rst(rst_a), .async_in(in_a), .evt_clr(clr_a),
      .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .evt_sticky(stk_a)
   );

   multi_chan_synchronizer #(
      .NUM_CHANNELS(8), .SYNC_STAGES(2), .DEBOUNCE_LEN(1), .RESET_VAL(8'h00)
   ) dut_b (
      .clk(clk), .rst(rst_b), .async_in(in_b), .evt_clr(clr_b),
      .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .evt_sticky(stk_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: inputs sampled at each edge since reset release.
   logic [15:0] hist [$];
   logic [15:0] m_level, m_rise, m_fall, m_sticky;

   // Synchronised value seen by the filter just before edge e.
   function automatic logic [15:0] s_before(input int e);
      if (e < SSA) return RVA;
      return hist[e-SSA];
   endfunction

   task automatic model_reset();
      m_level  = RVA;
      m_rise   = '0;
      m_fall   = '0;
      m_sticky = '0;
      hist.delete();
   endtask

   // A channel flips at edge e when the last DLA synchronised samples
   // (all taken since reset) disagree with the current level.
   task automatic model_edge(input logic [15:0] a, input logic [15:0] c);
      int          e;
      logic [15:0] flip, sv;
      bit          ok;
      e    = hist.size();
      flip = '0;
      for (int i = 0; i < NA; i++) begin
         ok = 1'b1;
         for (int k = 0; k < DLA; k++) begin
            if (e - k < 0) ok = 1'b0;
            else begin
               sv = s_before(e - k);
               if (sv[i] == m_level[i]) ok = 1'b0;
            end
         end
         flip[i] = ok;
      end
      hist.push_back(a);
      m_level  = m_level ^ flip;
      m_rise   = flip & m_level;
      m_fall   = flip & ~m_level;
      m_sticky = flip | (m_sticky & ~c);
   endtask

   task automatic check_a(input string nm);
      total++;
      if ({lvl_a, rise_a, fall_a, stk_a} !== {m_level, m_rise, m_fall, m_sticky}) begin
         bad++;
         $display("FAIL %s t=%0t: lvl/rise/fall/stk got %h %h %h %h want %h %h %h %h",
                  nm, $time, lvl_a, rise_a, fall_a, stk_a, m_level, m_rise, m_fall, m_sticky);
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got %h want %h", nm, $time, got, exp);
      end
   endtask

   // Drive new inputs ph after the previous sample point, take one edge,
   // advance the model (only while out of reset) and compare.
   task automatic tick_a(input logic [15:0] nin, input logic [15:0] nclr, input int ph,
                         input string nm);
      #(ph);
      in_a  = nin;
      clr_a = nclr;
      @(posedge clk);
      if (rst_a) model_edge(in_a, clr_a);
      #1 check_a(nm);
   endtask

   typedef struct {
      logic [7:0] ain;
      logic [7:0] clr;
      logic [7:0] lvl;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] stk;
   } vec_t;

   vec_t        tbl [20];
   logic [15:0] cur, rclr;
   int          hold [NA];

   initial begin
      tbl[0]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2]  = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
      tbl[3]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[4]  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[5]  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
      tbl[6]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
      tbl[7]  = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[8]  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[10] = '{8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 8'h80};
      tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
      tbl[12] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[13] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[14] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[15] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
      tbl[16] = '{8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
      tbl[17] = '{8'h0F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
      tbl[18] = '{8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'hFF};
      tbl[19] = '{8'h0F, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00};

      rst_a = 1'b1;
      rst_b = 1'b1;
      in_a  = RVA;
      clr_a = '0;
      in_b  = '0;
      clr_b = '0;
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      model_reset();
      #2;
      check_a("reset_a");
      chk("reset_a_lvl", lvl_a, RVA);
      chk("reset_b", {lvl_b, rise_b, fall_b, stk_b}, 16'h0000);
      #5 rst_b = 1'b1;

      // Unfiltered instance: one vector per clock.
      for (int r = 0; r < 20; r++) begin
         #3;
         in_b  = tbl[r].ain;
         clr_b = tbl[r].clr;
         @(posedge clk);
         #1;
         total++;
         if ({lvl_b, rise_b, fall_b, stk_b} !==
             {tbl[r].lvl, tbl[r].rise, tbl[r].fall, tbl[r].stk}) begin
            bad++;
            $display("FAIL vec%0d: lvl/rise/fall/stk got %h %h %h %h want %h %h %h %h", r,
                     lvl_b, rise_b, fall_b, stk_b,
                     tbl[r].lvl, tbl[r].rise, tbl[r].fall, tbl[r].stk);
         end
      end

      // Release with inputs equal to RESET_VAL: nothing may move.
      #2 rst_a = 1'b1;
      cur = RVA;
      for (int n = 0; n < 8; n++) tick_a(cur, '0, 3, "idle");
      chk("idle_lvl", lvl_a, RVA);
      chk("idle_stk", stk_a, '0);

      // Three-cycle glitch on channel 3 is swallowed.
      for (int n = 0; n < 3; n++) tick_a(cur | 16'h0008, '0, 3, "glitch");
      for (int n = 0; n < 10; n++) tick_a(cur, '0, 3, "glitch_after");
      chk("glitch_lvl", lvl_a, RVA);
      chk("glitch_pulse", rise_a | fall_a, '0);
      chk("glitch_stk", stk_a, '0);

      // Held high: level flips after edge 6.
      cur = cur | 16'h0008;
      for (int n = 0; n < 6; n++) tick_a(cur, '0, 3, "hold");
      chk("hold_e5_lvl3", {15'd0, lvl_a[3]}, 16'd0);
      tick_a(cur, '0, 3, "hold_e6");
      chk("hold_e6_lvl", lvl_a, RVA | 16'h0008);
      chk("hold_e6_rise", rise_a, 16'h0008);
      tick_a(cur, '0, 3, "hold_e7");
      chk("hold_e7_rise", rise_a, '0);
      chk("hold_e7_stk", stk_a, 16'h0008);

      // Fall on channel 5, clear, then clear coinciding with a rise.
      cur = cur & ~16'h0020;
      for (int n = 0; n < 7; n++) tick_a(cur, '0, 3, "fall5");
      chk("fall5_pulse", fall_a, 16'h0020);
      chk("fall5_stk", stk_a, 16'h0028);
      tick_a(cur, 16'h0020, 3, "clr5");
      chk("clr5_stk", stk_a, 16'h0008);
      cur = cur | 16'h0020;
      for (int n = 0; n < 6; n++) tick_a(cur, '0, 3, "rise5");
      tick_a(cur, 16'h0020, 3, "rise5_clr");
      chk("rise5_pulse", rise_a, 16'h0020);
      chk("rise5_stk", stk_a, 16'h0028);
      tick_a(cur, '0, 3, "rise5_after");
      chk("rise5_after_stk", stk_a, 16'h0028);

      // Reset in the middle of a debounce on channel 1.
      cur = cur | 16'h0002;
      for (int n = 0; n < 5; n++) tick_a(cur, '0, 3, "pre_rst");
      #3 rst_a = 1'b0;
      model_reset();
      #1;
      chk("midrst_lvl", lvl_a, RVA);
      chk("midrst_pulse", rise_a | fall_a, '0);
      chk("midrst_stk", stk_a, '0);
      tick_a(cur, '0, 1, "in_rst");
      #2 rst_a = 1'b1;
      for (int n = 0; n < 6; n++) tick_a(cur, '0, 3, "post_rst");
      chk("post_rst_e5_lvl", lvl_a, RVA);
      tick_a(cur, '0, 3, "post_rst_e6");
      chk("post_rst_e6_lvl", lvl_a, RVA | 16'h000A);
      chk("post_rst_e6_rise", rise_a, 16'h000A);

      // Randomised toggling, random hold times (some shorter than the filter).
      for (int i = 0; i < NA; i++) hold[i] = 1;
      for (int n = 0; n < 2500; n++) begin
         for (int i = 0; i < NA; i++) begin
            hold[i]--;
            if (hold[i] == 0) begin
               cur[i]  = ~cur[i];
               hold[i] = $urandom_range(1, 7);
            end
         end
         rclr = 16'($urandom & $urandom & $urandom);
         if (n == 1000 || n == 1800) begin
            #2 rst_a = 1'b0;
            model_reset();
            #1 check_a("rand_rst");
            tick_a(cur, rclr, 1, "rand_in_rst");
            #2 rst_a = 1'b1;
         end
         tick_a(cur, rclr, $urandom_range(1, 5), "rand");
         chk("rand_excl", rise_a & fall_a, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_chan_synchronizer.md
# multi_chan_synchronizer

Parameterised multi-channel synchroniser that brings asynchronous single-bit signals (pins, status lines from foreign clock domains) into one destination clock domain. Each channel runs through a configurable-depth flop chain, an optional debounce filter, and edge detection. The block provides clean levels, single-cycle edge pulses and software-clearable sticky event flags. It sits at the boundary of every block that consumes asynchronous control or status inputs.

## Interface
Parameters:
- NUM_CHANNELS, 8: number of independent single-bit channels (1..64).
- SYNC_STAGES, 2: flops in each synchroniser chain (2..4).
- DEBOUNCE_LEN, 1: consecutive stable cycles required before the output level changes (1..65535); 1 means no filtering.
- RESET_VAL, 0: NUM_CHANNELS-bit reset value of the chain flops and of level_out.

Ports:
- clk  input  1  destination clock; all logic is in this domain.
- rst  input  1  asynchronous, active-low reset.
- async_in  input  NUM_CHANNELS  asynchronous inputs; no timing relationship to clk.
- evt_clr  input  NUM_CHANNELS  synchronous per-channel clear of evt_sticky.
- level_out  output  NUM_CHANNELS  synchronised, debounced level.
- rise_pulse  output  NUM_CHANNELS  one-cycle pulse on a 0->1 change of level_out.
- fall_pulse  output  NUM_CHANNELS  one-cycle pulse on a 1->0 change of level_out.
- evt_sticky  output  NUM_CHANNELS  set on any level_out change; held until cleared.

## Operation
- Reset (rst low, asynchronous): chain flops and level_out = RESET_VAL; debounce counters = 0; rise_pulse, fall_pulse, evt_sticky = 0.
- Sync chain: async_in[i] -> SYNC_STAGES flops. The last stage is s[i]. No logic between stages. Chain flops carry the synthesis ASYNC_REG attribute.
- Debounce, per channel. The counter width is max(1, clog2(DEBOUNCE_LEN)).
  - If s == level_out: counter <= 0.
  - If s != level_out and counter == DEBOUNCE_LEN-1: level_out <= s and counter <= 0.
  - Otherwise: counter <= counter + 1.
  - The counter never exceeds DEBOUNCE_LEN-1, so it cannot wrap.
- Edge pulses: registered, and set on the same edge that flips level_out.
  - rise_pulse[i] = 1 for exactly one cycle when level_out[i] becomes 1.
  - fall_pulse[i] = 1 for exactly one cycle when level_out[i] becomes 0.
  - rise_pulse and fall_pulse are never both high on one channel.
- Sticky flag: evt_sticky[i] is set on the edge where level_out[i] flips. It is cleared on an edge where evt_clr[i] = 1. If a flip and evt_clr[i] occur on the same edge, set wins.
- Channels are fully independent. No cross-channel coherency is provided; buses must not be passed through this block.

## Timing
- Take edge 0 as the first clk edge that samples a new async_in value.
  - s changes after edge SYNC_STAGES-1.
  - level_out and the pulse change after edge SYNC_STAGES+DEBOUNCE_LEN-1.
  - Latency is SYNC_STAGES+DEBOUNCE_LEN-1 cycles; it is SYNC_STAGES when DEBOUNCE_LEN = 1.
- Glitch rejection: a change of s that reverts before DEBOUNCE_LEN consecutive cycles resets the counter. It produces no level change, pulse or sticky set.
- Metastability: an input toggling near a clk edge may add one cycle of latency; the outcome must still be a single clean transition.
- Release from reset: if async_in differs from RESET_VAL, level_out transitions after normal latency and produces a pulse and a sticky set. This is required behaviour.
- Reset mid-debounce: all counters and pulses clear immediately, and no pending transition completes.
- Minimum detectable input pulse width: DEBOUNCE_LEN clk periods plus one clk period of sampling uncertainty.

## Test plan
- Latency: SYNC_STAGES=2, DEBOUNCE_LEN=1, RESET_VAL=0. Raise async_in[0] before edge 0 -> level_out[0]=1 and rise_pulse[0]=1 after edge 2; rise_pulse[0] is back to 0 after edge 3.
- Debounce: SYNC_STAGES=3, DEBOUNCE_LEN=4.
  - async_in[3] high for 3 cycles then low -> no level, pulse or sticky change.
  - async_in[3] held high -> level_out[3]=1 after edge 6.
- Sticky/clear: cause a fall on channel 5 -> evt_sticky[5]=1. Pulse evt_clr[5] for one cycle -> evt_sticky[5]=0. Assert evt_clr[5] on the same edge as a new rise -> evt_sticky[5] stays 1.
- Reset: RESET_VAL=8'hA5 with async_in=8'hA5.
  - Pulse rst low -> level_out=8'hA5 immediately and no pulses.
  - Assert rst mid-debounce on channel 1 -> after release, channel 1 requires the full DEBOUNCE_LEN again.
- Randomised channels: NUM_CHANNELS=16, independent random async toggling with random phase to clk.
  - Scoreboard checks per-channel latency, glitch rejection, rise/fall mutual exclusion, and one pulse per level change.
